// File: rtl/bus_pkg.sv
// Shared encodings, FSM state type, default address map and byte-enable helper
// for the core-side memory bus responder.
package bus_pkg;

   localparam logic [2:0] SZ_BYTE = 3'd0;
   localparam logic [2:0] SZ_HALF = 3'd1;
   localparam logic [2:0] SZ_WORD = 3'd2;

   localparam logic [31:0] DEF_RAM_BASE    = 32'h0000_1000;
   localparam int          DEF_RAM_WORDS   = 1024;
   localparam logic [31:0] DEF_STDOUT_ADDR = 32'h0000_3000;
   localparam logic [31:0] DEF_STDIN_ADDR  = 32'h0000_3004;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAM,
      ST_OUT,
      ST_IN,
      ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      ACT_RAM,
      ACT_OUT,
      ACT_IN,
      ACT_ERR
   } action_t;

   // Lane mask for an access; only meaningful for aligned, legal sizes.
   function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 4'b0001 << lane;
         SZ_HALF: return 4'b0011 << lane;
         SZ_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/bus_ram_bytelane.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read
// port, written in a form that maps onto block RAM.
module bus_ram_bytelane #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: no reset on the array or its output register; a reset would stop
   // the memory from mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         // Output only changes on reads, so a completed read stays visible.
         if (we == 4'b0000) rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/bus_responder.sv
// Memory-bus responder: byte-lane RAM plus stdout/stdin MMIO ports toward the
// tty transmitter/receiver, answering each request with a single ready pulse.
module bus_responder
   import bus_pkg::*;
#(
   parameter logic [31:0] RAM_BASE    = DEF_RAM_BASE,
   parameter int          RAM_WORDS   = DEF_RAM_WORDS,
   parameter logic [31:0] STDOUT_ADDR = DEF_STDOUT_ADDR,
   parameter logic [31:0] STDIN_ADDR  = DEF_STDIN_ADDR
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        valid,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        stdout_valid,
   output logic [7:0]  stdout_data,
   input  logic        stdout_ready,
   output logic        stdin_valid,
   input  logic [7:0]  stdin_data,
   input  logic        stdin_ready
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

   state_t      state;
   action_t     action;
   logic        aligned;
   logic        accept;
   logic [31:0] offset;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_q;
   logic [31:0] rdata_q;
   logic        from_ram;

   // Addresses below RAM_BASE wrap to large offsets and fall outside the range.
   assign offset = addr - RAM_BASE;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      aligned = 1'b0;
      case (size)
         SZ_BYTE: aligned = 1'b1;
         SZ_HALF: aligned = ~addr[0];
         SZ_WORD: aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   always_comb begin
      action = ACT_ERR;
      if (size > SZ_WORD || !aligned)              action = ACT_ERR;
      else if (offset < RAM_BYTES)                 action = ACT_RAM;
      else if (addr == STDOUT_ADDR && write)       action = ACT_OUT;
      else if (addr == STDIN_ADDR && !write)       action = ACT_IN;
   end

   assign accept = (state == ST_IDLE) && valid;
   assign ram_en = accept && (action == ACT_RAM);
   assign ram_we = (ram_en && write) ? byte_enable(size, addr[1:0]) : 4'b0000;

   bus_ram_bytelane #(
      .DEPTH (RAM_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (offset[AW+1:2]),
      .wdata (wdata),
      .rdata (ram_q)
   );

   // RAM reads come straight from the RAM output register; everything else
   // (stdin bytes, error zeros, reset) comes from rdata_q.
   assign rdata = from_ram ? ram_q : rdata_q;

   // NOTE: state and outputs are sequential, so they use non-blocking
   // assignments; every read in this block sees pre-edge values.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state        <= ST_IDLE;
         ready        <= 1'b0;
         err          <= 1'b0;
         stdout_valid <= 1'b0;
         stdout_data  <= 8'h00;
         stdin_valid  <= 1'b0;
         rdata_q      <= 32'h0;
         from_ram     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid) begin
                  case (action)
                     ACT_RAM: begin
                        if (!write) from_ram <= 1'b1;
                        ready <= 1'b1;
                        state <= ST_RESP;
                     end
                     ACT_OUT: begin
                        stdout_data  <= wdata[7:0];
                        stdout_valid <= 1'b1;
                        state        <= ST_OUT;
                     end
                     ACT_IN: begin
                        stdin_valid <= 1'b1;
                        state       <= ST_IN;
                     end
                     default: begin
                        rdata_q  <= 32'h0;
                        from_ram <= 1'b0;
                        err      <= 1'b1;
                        ready    <= 1'b1;
                        state    <= ST_RESP;
                     end
                  endcase
               end
            end
            // Port handshakes finish even if the core drops valid meanwhile.
            ST_OUT: begin
               if (stdout_ready) begin
                  stdout_valid <= 1'b0;
                  ready        <= 1'b1;
                  state        <= ST_RESP;
               end
            end
            ST_IN: begin
               if (stdin_ready) begin
                  stdin_valid <= 1'b0;
                  rdata_q     <= {24'h0, stdin_data};
                  from_ram    <= 1'b0;
                  ready       <= 1'b1;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               ready <= 1'b0;
               err   <= 1'b0;
               state <= ST_IDLE;
            end
            // ST_RAM is part of the state encoding but RAM accesses answer
            // straight from RESP; any stray encoding recovers to IDLE.
            default: begin
               ready <= 1'b0;
               err   <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: expected responses are queued as each
// request is driven and compared when ready arrives.
module tb_bus_responder;
   import bus_pkg::*;

   logic        clk;
   logic        rstb;
   logic        valid;
   logic        write;
   logic [31:0] addr;
   logic [2:0]  size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        stdout_valid;
   logic [7:0]  stdout_data;
   logic        stdout_ready;
   logic        stdin_valid;
   logic [7:0]  stdin_data;
   logic        stdin_ready;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   out_hi = 0;
   int   in_hi  = 0;

   bus_responder dut (
      .clk          (clk),
      .rstb         (rstb),
      .valid        (valid),
      .write        (write),
      .addr         (addr),
      .size         (size),
      .wdata        (wdata),
      .rdata        (rdata),
      .ready        (ready),
      .err          (err),
      .stdout_valid (stdout_valid),
      .stdout_data  (stdout_data),
      .stdout_ready (stdout_ready),
      .stdin_valid  (stdin_valid),
      .stdin_data   (stdin_data),
      .stdin_ready  (stdin_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles during which each port request is held high.
   always @(negedge clk) begin
      if (stdout_valid === 1'b1) out_hi++;
      if (stdin_valid === 1'b1)  in_hi++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one request, waits (bounded) for ready, then checks the response
   // and that ready is gone on the following cycle.
   task automatic do_req(input string tag, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat);
      int   cyc;
      exp_t e;
      write = wr;
      addr  = a;
      size  = sz;
      wdata = wd;
      valid = 1'b1;
      sb.push_back('{exp_rdata, exp_err});
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (ready !== 1'b1 && cyc < 200);
      e = sb.pop_front();
      check({tag, " ready"},   {31'b0, ready}, 32'd1);
      check({tag, " latency"}, cyc,            exp_lat);
      check({tag, " rdata"},   rdata,          e.rdata);
      check({tag, " err"},     {31'b0, err},   {31'b0, e.err});
      @(posedge clk);
      #1;
      check({tag, " pulse"},   {31'b0, ready}, 32'd0);
      valid = 1'b0;
   endtask

   initial begin
      int base;
      int n;

      rstb         = 1'b0;
      valid        = 1'b0;
      write        = 1'b0;
      addr         = 32'h0;
      size         = 3'd0;
      wdata        = 32'h0;
      stdout_ready = 1'b0;
      stdin_data   = 8'h00;
      stdin_ready  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst ready",        {31'b0, ready},        32'd0);
      check("rst err",          {31'b0, err},          32'd0);
      check("rst rdata",        rdata,                 32'd0);
      check("rst stdout_valid", {31'b0, stdout_valid}, 32'd0);
      check("rst stdout_data",  {24'b0, stdout_data},  32'd0);
      check("rst stdin_valid",  {31'b0, stdin_valid},  32'd0);
      @(negedge clk);
      rstb = 1'b1;
      @(posedge clk);
      #1;

      // Word and byte-lane RAM traffic.
      do_req("wr_word",  1'b1, 32'h1000, SZ_WORD, 32'hDEADBEEF, 32'h0,        1'b0, 1);
      do_req("rd_word",  1'b0, 32'h1000, SZ_WORD, 32'h0,        32'hDEADBEEF, 1'b0, 1);
      do_req("wr_zero",  1'b1, 32'h1004, SZ_WORD, 32'h0,        32'hDEADBEEF, 1'b0, 1);
      do_req("wr_byte",  1'b1, 32'h1006, SZ_BYTE, 32'h00AB0000, 32'hDEADBEEF, 1'b0, 1);
      do_req("rd_byte",  1'b0, 32'h1004, SZ_WORD, 32'h0,        32'h00AB0000, 1'b0, 1);
      do_req("wr_half",  1'b1, 32'h1006, SZ_HALF, 32'h12340000, 32'h00AB0000, 1'b0, 1);
      do_req("rd_half",  1'b0, 32'h1004, SZ_WORD, 32'h0,        32'h12340000, 1'b0, 1);

      // stdout: tty_tx stalls 5 cycles after the byte is offered.
      base = out_hi;
      fork
         do_req("stdout", 1'b1, 32'h3000, SZ_BYTE, 32'h00000041, 32'h12340000, 1'b0, 7);
         begin
            n = 0;
            while (stdout_valid !== 1'b1 && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            check("stdout offered", {31'b0, stdout_valid}, 32'd1);
            check("stdout_data",    {24'b0, stdout_data},  32'h41);
            repeat (5) @(posedge clk);
            #1;
            stdout_ready = 1'b1;
            @(posedge clk);
            #1;
            stdout_ready = 1'b0;
         end
      join
      check("stdout_valid cycles", out_hi - base, 32'd6);

      // stdin: tty_rx answers 3 cycles after the request.
      base = in_hi;
      stdin_data = 8'h5A;
      fork
         do_req("stdin", 1'b0, 32'h3004, SZ_WORD, 32'h0, 32'h0000005A, 1'b0, 5);
         begin
            n = 0;
            while (stdin_valid !== 1'b1 && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            check("stdin requested", {31'b0, stdin_valid}, 32'd1);
            repeat (3) @(posedge clk);
            #1;
            stdin_ready = 1'b1;
            @(posedge clk);
            #1;
            stdin_ready = 1'b0;
         end
      join
      check("stdin_valid cycles", in_hi - base, 32'd4);

      // Error cases: no side effects on RAM or tty ports, rdata cleared.
      base = out_hi;
      n    = in_hi;
      do_req("err_mis_word",  1'b1, 32'h1002, SZ_WORD, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
      do_req("err_size3",     1'b1, 32'h1000, 3'd3,    32'hFFFFFFFF, 32'h0, 1'b1, 1);
      do_req("err_unmapped",  1'b0, 32'h4000, SZ_WORD, 32'h0,        32'h0, 1'b1, 1);
      do_req("err_wr_stdin",  1'b1, 32'h3004, SZ_WORD, 32'h00000055, 32'h0, 1'b1, 1);
      do_req("err_rd_stdout", 1'b0, 32'h3000, SZ_WORD, 32'h0,        32'h0, 1'b1, 1);
      do_req("err_mis_half",  1'b1, 32'h1001, SZ_HALF, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
      do_req("err_ram_end",   1'b0, 32'h2000, SZ_WORD, 32'h0,        32'h0, 1'b1, 1);
      do_req("err_below_ram", 1'b1, 32'h0FFC, SZ_WORD, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
      check("err no stdout", out_hi - base, 32'd0);
      check("err no stdin",  in_hi - n,     32'd0);
      do_req("rd_after_err", 1'b0, 32'h1000, SZ_WORD, 32'h0, 32'hDEADBEEF, 1'b0, 1);

      // Last RAM word.
      do_req("wr_last", 1'b1, 32'h1FFC, SZ_WORD, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1);
      do_req("rd_last", 1'b0, 32'h1FFC, SZ_WORD, 32'h0,        32'hCAFEF00D, 1'b0, 1);

      // Reset while a stdout byte is pending.
      write        = 1'b1;
      addr         = 32'h3000;
      size         = SZ_BYTE;
      wdata        = 32'h0000007E;
      valid        = 1'b1;
      stdout_ready = 1'b0;
      n = 0;
      while (stdout_valid !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("mid_out offered", {31'b0, stdout_valid}, 32'd1);
      #2;
      rstb = 1'b0;
      #1;
      check("async stdout_valid", {31'b0, stdout_valid}, 32'd0);
      check("async stdout_data",  {24'b0, stdout_data},  32'd0);
      check("async ready",        {31'b0, ready},        32'd0);
      check("async err",          {31'b0, err},          32'd0);
      check("async rdata",        rdata,                 32'd0);
      check("async stdin_valid",  {31'b0, stdin_valid},  32'd0);
      valid = 1'b0;
      @(posedge clk);
      #1;
      check("held stdout_valid", {31'b0, stdout_valid}, 32'd0);
      rstb = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst stdout_valid", {31'b0, stdout_valid}, 32'd0);
      do_req("rd_post_rst", 1'b0, 32'h1000, SZ_WORD, 32'h0, 32'hDEADBEEF, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
